// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response port plus the decode-side
// instruction port with its pre-sliced fields and next-PC select/target.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  func7;
  logic [1:0]  PC_genrator_sel;
  logic [31:0] target_addr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output instr_valid, instr, pc_out, opcode, rd, func3, rs1, rs2, func7,
    input  instr_ready, PC_genrator_sel, target_addr
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  instr_valid, instr, pc_out, opcode, rd, func3, rs1, rs2, func7,
    output instr_ready, PC_genrator_sel, target_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry {pc, word} buffer, redirect on taken branch/jalr.
// Head valid the cycle after the response; requests stall while buffer + in-flight would exceed 2.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic {S_FETCH, S_WAIT} state_t;

  state_t      r_state;
  logic [31:0] r_next_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_tgt_pc;
  logic        r_tgt_vld;
  logic        r_outstanding;
  logic        r_discard;
  logic [31:0] r_fifo_pc   [2];
  logic [31:0] r_fifo_word [2];
  logic        r_head;
  logic        r_tail;
  logic [1:0]  r_count;

  logic        w_req_valid;
  logic        w_req_fire;
  logic        w_instr_valid;
  logic        w_pop;
  logic        w_redirect;
  logic        w_resp_fire;
  logic        w_push;
  logic [31:0] w_target;
  logic [31:0] w_instr;

  assign w_req_valid   = !reset && (r_state == S_FETCH) &&
                         (({1'b0, r_count} + {2'b00, r_outstanding}) < 3'd2);
  assign w_req_fire    = w_req_valid && bus.imem_req_ready;
  assign w_instr_valid = !reset && (r_count != 2'd0);
  assign w_pop         = w_instr_valid && bus.instr_ready;
  assign w_redirect    = w_pop && ((bus.PC_genrator_sel == 2'b01) || (bus.PC_genrator_sel == 2'b10));
  assign w_resp_fire   = (r_state == S_WAIT) && r_outstanding && bus.imem_resp_valid;
  assign w_push        = w_resp_fire && !r_discard;
  assign w_target      = bus.target_addr & ~32'h3;
  assign w_instr       = w_instr_valid ? r_fifo_word[r_head] : 32'h0;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = reset ? 32'h0 : r_next_pc;
  assign bus.instr_valid    = w_instr_valid;
  assign bus.instr          = w_instr;
  assign bus.pc_out         = w_instr_valid ? r_fifo_pc[r_head] : 32'h0;
  assign bus.opcode         = w_instr[6:0];
  assign bus.rd             = w_instr[11:7];
  assign bus.func3          = w_instr[14:12];
  assign bus.rs1            = w_instr[19:15];
  assign bus.rs2            = w_instr[24:20];
  assign bus.func7          = w_instr[31:25];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_next_pc     <= RESET_PC;
      r_req_pc      <= 32'h0;
      r_tgt_pc      <= 32'h0;
      r_tgt_vld     <= 1'b0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      r_head        <= 1'b0;
      r_tail        <= 1'b0;
      r_count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_pc[i]   <= 32'h0;
        r_fifo_word[i] <= 32'h0;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_req_fire) begin
            r_state       <= S_WAIT;
            r_outstanding <= 1'b1;
            r_req_pc      <= r_next_pc;
          end
        end
        S_WAIT: begin
          if (w_resp_fire) begin
            r_state       <= S_FETCH;
            r_outstanding <= 1'b0;
          end
        end
        default: r_state <= S_FETCH;
      endcase

      // A stalled request must keep its address, so a redirect seen while it is
      // pending is parked in r_tgt_pc and applied when the request is accepted.
      if (w_req_fire) begin
        if (w_redirect)     r_next_pc <= w_target;
        else if (r_tgt_vld) r_next_pc <= r_tgt_pc;
        else                r_next_pc <= r_next_pc + 32'd4;
        r_tgt_vld <= 1'b0;
      end else if (w_redirect) begin
        if (w_req_valid) begin
          r_tgt_pc  <= w_target;
          r_tgt_vld <= 1'b1;
        end else begin
          r_next_pc <= w_target;
        end
      end

      if (w_redirect && (w_req_valid || (r_outstanding && !w_resp_fire)))
        r_discard <= 1'b1;
      else if (w_resp_fire)
        r_discard <= 1'b0;

      if (w_redirect) begin
        r_count <= 2'd0;
        r_head  <= 1'b0;
        r_tail  <= 1'b0;
      end else begin
        if (w_push) begin
          r_fifo_pc[r_tail]   <= r_req_pc;
          r_fifo_word[r_tail] <= bus.imem_resp_data;
          r_tail              <= ~r_tail;
        end
        if (w_pop) r_head <= ~r_head;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
